load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory stage directly downstream of the RV32I datapath.
- Consumes the datapath's ALU result (the effective address) and its rs2 read data (the store data).
- Performs byte/half/word loads and stores over a valid/ready data-bus handshake, then returns extended load data to the register write-back mux.
- Asserts stall to freeze the PC register and regfile write enable while an access is outstanding.

Parameters:
- ADDR_W, 32, address width on core and bus side.
- DATA_W, 32, data width; fixed at 32 for RV32I lane logic.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  current instruction is a load.
- mem_write  in  1  current instruction is a store; wins if asserted together with mem_read.
- funct3  in  3  access size/sign, instruction bits [14:12].
- addr  in  32  effective address from the ALU result.
- w_data  in  32  store data from rs2.
- load_data  out  32  extended load result, to the write-back mux.
- stall  out  1  hold PC and suppress RegWrite.
- done  out  1  one-cycle pulse when the access completes.
- misalign_err  out  1  misaligned access flag; tied 0 when the optional feature is compiled out.
- bus_req  out  1  bus request valid.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_wstrb  out  4  byte enables; 0 for reads.
- bus_ready  in  1  bus accepts the request this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data.

Behaviour:
- Reset: state IDLE; every output 0, including load_data.
- Reset mid-access abandons the access: bus_req drops on the next edge, and no done or load_data update occurs.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On mem_read|mem_write, register addr, w_data, funct3 and the write flag, then go to REQ.
  - stall is asserted combinationally in this same cycle.
- REQ:
  - bus_req=1 with all bus_* outputs registered and held stable until bus_ready=1.
  - On handshake, a store goes to DONE.
  - On handshake, a load goes to DONE if bus_rvalid is also high this cycle, otherwise to WAIT.
- WAIT: hold until bus_rvalid; capture the extended bus_rdata into load_data, then go to DONE.
- DONE:
  - stall=0 and done=1 for exactly one cycle, so the core retires the instruction on this edge.
  - Always returns to IDLE. The next instruction is sampled only in IDLE, so the same access is never re-issued.
- stall = (IDLE & (mem_read|mem_write)) | REQ | WAIT.
- Latency: minimum 3 cycles (IDLE, REQ, DONE); each extra wait cycle adds one.
- bus_rvalid outside REQ/WAIT is ignored.
- Store lanes, with o = addr[1:0]:
  - SB (000): wstrb = 0001<<o, wdata = {4{w_data[7:0]}}.
  - SH (001): wstrb = 0011<<{o[1],0}, wdata = {2{w_data[15:0]}}.
  - SW (010): wstrb = 1111.
- Load extraction:
  - LB and LBU (000, 100) select byte o; LB sign-extends, LBU zero-extends.
  - LH and LHU (001, 101) select halfword o[1]; LH sign-extends, LHU zero-extends.
  - LW (010) is passed through unchanged.
- Reserved funct3 (011, 110, 111) is treated as a word access.
- load_data holds its value until the next load completes; stores never change it.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misalignment is detected in IDLE: halfword access with addr[0]=1, or word access with addr[1:0]!=0.
  - A misaligned access goes IDLE→DONE with no bus request.
  - misalign_err=1 together with done; load_data is unchanged.
- Undefined:
  - No detection; misalign_err is tied 0.
  - The low address bits are forced aligned (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds normally.

Decomposition:
- lsu_pkg:
  - state enum lsu_state_t {IDLE, REQ, WAIT, DONE}.
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
- One combinational sub-module, lsu_align:
  - Inputs: funct3, offset, w_data, bus_rdata.
  - Outputs: wstrb, replicated wdata, extended load data.

Test Plan:
- SW addr=0x100, w_data=0xDEADBEEF, bus_ready=1 immediately → bus_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; done in cycle 3; stall high for cycles 1–2.
- LB addr=0x203, bus_rdata=0x80FF_7F01, rvalid together with ready → load_data=0xFFFFFF80. The same access as LBU → 0x00000080.
- SH addr=0x302, w_data=0x0000ABCD, bus_ready delayed 3 cycles → bus outputs stable throughout; wstrb=1100, wdata=0xABCDABCD; done in cycle 6.
- LH addr=0x400, ready in REQ, rvalid 2 cycles later, bus_rdata=0x1234_8001 → WAIT lasts 2 cycles; load_data=0xFFFF8001; stall released only in DONE.
- rst asserted while in WAIT → next cycle state IDLE, bus_req=0, stall=0, no done pulse; a late rvalid is ignored.
- LW addr=0x502:
  - With LSU_MISALIGN_TRAP_EN: done=1 and misalign_err=1 in cycle 2, bus_req never asserted.
  - Without it: bus_addr=0x500, normal completion.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and funct3 decode helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_byte(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] f3);
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

  // Reserved encodings fall into the word class
  function automatic logic is_word(input logic [2:0] f3);
    return !is_byte(f3) && !is_half(f3);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/replication and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] w_data,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic        sign_ext;

  always_comb begin
    rbyte     = bus_rdata[{offset, 3'b000} +: 8];
    rhalf     = offset[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    sign_ext  = ~funct3[2];
    wstrb     = 4'b1111;
    wdata     = w_data;
    load_data = bus_rdata;
    if (is_byte(funct3)) begin
      wstrb     = 4'b0001 << offset;
      wdata     = {4{w_data[7:0]}};
      load_data = {{24{sign_ext & rbyte[7]}}, rbyte};
    end else if (is_half(funct3)) begin
      wstrb     = offset[1] ? 4'b1100 : 4'b0011;
      wdata     = {2{w_data[15:0]}};
      load_data = {{16{sign_ext & rhalf[15]}}, rhalf};
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: sized loads/stores over a valid/ready bus with core stall.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] load_data,
  output logic              stall,
  output logic              done,
  output logic              misalign_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_ready,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
);

  lsu_state_t        state_q, state_d;
  logic              we_q, mis_q, mis_c, access;
  logic [2:0]        f3_q, al_f3;
  logic [1:0]        off_q, off_c, al_off;
  logic [3:0]        wstrb_c;
  logic [DATA_W-1:0] wdata_c, ld_c;

  assign access = mem_read | mem_write;

  // Halfword/word offsets are forced aligned; only byte accesses keep addr[1:0]
  always_comb begin
    off_c = addr[1:0];
    if (is_half(funct3)) begin
      off_c = {addr[1], 1'b0};
    end else if (is_word(funct3)) begin
      off_c = 2'b00;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_c = (is_half(funct3) & addr[0]) | (is_word(funct3) & (addr[1:0] != 2'b00));
`else
  assign mis_c = 1'b0;
`endif

  // Store lanes come from live inputs in IDLE; load extraction uses captured size/offset
  assign al_f3  = (state_q == IDLE) ? funct3 : f3_q;
  assign al_off = (state_q == IDLE) ? off_c  : off_q;

  lsu_align u_align (
    .funct3    (al_f3),
    .offset    (al_off),
    .w_data    (w_data),
    .bus_rdata (bus_rdata),
    .wstrb     (wstrb_c),
    .wdata     (wdata_c),
    .load_data (ld_c)
  );

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    done         = 1'b0;
    misalign_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          stall   = ~rst;
          state_d = mis_c ? DONE : REQ;
        end
      end
      REQ: begin
        stall = ~rst;
        if (bus_ready) begin
          state_d = (we_q || bus_rvalid) ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall = ~rst;
        if (bus_rvalid) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        misalign_err = mis_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      mis_q     <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      load_data <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= 4'b0000;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (access) begin
            we_q      <= mem_write;
            mis_q     <= mis_c;
            f3_q      <= funct3;
            off_q     <= off_c;
            bus_req   <= ~mis_c;
            bus_we    <= mem_write & ~mis_c;
            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus_wdata <= wdata_c;
            bus_wstrb <= (mem_write & ~mis_c) ? wstrb_c : 4'b0000;
          end
        end
        REQ: begin
          if (bus_ready) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_wstrb <= 4'b0000;
            if (!we_q && bus_rvalid) begin
              load_data <= ld_c;
            end
          end
        end
        WAIT: begin
          if (bus_rvalid) begin
            load_data <= ld_c;
          end
        end
        DONE: mis_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table, bus responder and load-data scoreboard.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, w_data, load_data;
  logic        stall, done, misalign_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready, bus_rvalid;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .w_data(w_data), .load_data(load_data),
    .stall(stall), .done(done), .misalign_err(misalign_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ready(bus_ready),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rd;
    int          rdy_dly, rv_dly;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_load;
    int          e_lat;
    logic        e_trap;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  logic [31:0] model_load;
  int          checks = 0;
  int          errors = 0;

  function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int rdy,
                              input int rv, input logic [31:0] ea, input logic [3:0] es,
                              input logic [31:0] ew, input logic [31:0] el, input int lat,
                              input logic trap);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = a; v.wd = wd; v.rd = rd; v.rdy_dly = rdy; v.rv_dly = rv;
    v.e_addr = ea; v.e_strb = es; v.e_wdata = ew; v.e_load = el; v.e_lat = lat; v.e_trap = trap;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
  endtask

  // One full access: drive, act as bus responder, check bus fields and completion
  task automatic run_vec(input vec_t v, input string tag);
    int n, wcnt, rcnt;
    bit fin;
    logic [31:0] exp;
    @(negedge clk);
    mem_write = v.wr; mem_read = !v.wr; funct3 = v.f3; addr = v.addr;
    w_data = v.wd; bus_rdata = v.rd;
    exp = (v.wr || v.e_trap) ? model_load : v.e_load;
    model_load = exp;
    sb.push_back(exp);
    #1 check1({tag, " stall_cycle1"}, stall, 1'b1);
    n = 1; wcnt = 0; rcnt = 0; fin = 0;
    while (!fin) begin
      @(negedge clk);
      n++;
      if (done) begin
        fin = 1;
        check({tag, " latency"}, 32'(n), 32'(v.e_lat));
        check1({tag, " stall_in_done"}, stall, 1'b0);
        check1({tag, " misalign_err"}, misalign_err, v.e_trap);
        check({tag, " load_data"}, load_data, sb.pop_front());
        idle_inputs();
      end else if (n > 30) begin
        fin = 1;
        checks++; errors++;
        $display("FAIL %s timeout: got no done after %0d cycles, expected done", tag, n);
        void'(sb.pop_front());
        idle_inputs();
      end else begin
        check1({tag, " stall_busy"}, stall, 1'b1);
        check1({tag, " misalign_early"}, misalign_err, 1'b0);
        if (v.e_trap) check1({tag, " trap_no_req"}, bus_req, 1'b0);
        if (bus_req) begin
          check1({tag, " bus_we"}, bus_we, v.wr);
          check({tag, " bus_addr"}, bus_addr, v.e_addr);
          check({tag, " bus_wstrb"}, 32'(bus_wstrb), 32'(v.e_strb));
          if (v.wr) check({tag, " bus_wdata"}, bus_wdata, v.e_wdata);
          bus_ready  = (wcnt >= v.rdy_dly);
          wcnt++;
          bus_rvalid = !v.wr && bus_ready && (v.rv_dly == 0);
        end else begin
          rcnt++;
          bus_ready  = 1'b0;
          bus_rvalid = (rcnt >= v.rv_dly);
        end
      end
    end
    @(negedge clk);
    check1({tag, " done_one_cycle"}, done, 1'b0);
    check1({tag, " req_after"}, bus_req, 1'b0);
    check1({tag, " stall_after"}, stall, 1'b0);
  endtask

  initial begin
    rst = 1'b1; funct3 = 3'b000; addr = '0; w_data = '0; bus_rdata = '0;
    idle_inputs();
    model_load = '0;

    //       wr f3     addr      w_data        rdata        rdy rv  e_addr    strb  e_wdata       e_load        lat trap
    vecs.push_back(mk(1, F3_W,  32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0,        3, 0));
    vecs.push_back(mk(0, F3_B,  32'h203, 32'h0,        32'h80FF7F01, 0, 0, 32'h200, 4'h0, 32'h0,        32'hFFFFFF80, 3, 0));
    vecs.push_back(mk(0, F3_BU, 32'h203, 32'h0,        32'h80FF7F01, 0, 0, 32'h200, 4'h0, 32'h0,        32'h00000080, 3, 0));
    vecs.push_back(mk(1, F3_H,  32'h302, 32'h0000ABCD, 32'h0,        3, 0, 32'h300, 4'hC, 32'hABCDABCD, 32'h0,        6, 0));
    vecs.push_back(mk(0, F3_H,  32'h400, 32'h0,        32'h12348001, 0, 2, 32'h400, 4'h0, 32'h0,        32'hFFFF8001, 5, 0));
    vecs.push_back(mk(1, F3_B,  32'h101, 32'h12345655, 32'h0,        1, 0, 32'h100, 4'h2, 32'h55555555, 32'h0,        4, 0));
    vecs.push_back(mk(0, F3_HU, 32'h402, 32'h0,        32'h12348001, 1, 1, 32'h400, 4'h0, 32'h0,        32'h00001234, 5, 0));
    vecs.push_back(mk(0, F3_B,  32'h201, 32'h0,        32'h80FF7F01, 0, 0, 32'h200, 4'h0, 32'h0,        32'h0000007F, 3, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, F3_W,  32'h502, 32'h0,        32'hCAFEF00D, 0, 0, 32'h0,   4'h0, 32'h0,        32'h0,        2, 1));
    vecs.push_back(mk(1, F3_H,  32'h303, 32'h1111BEEF, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0,        32'h0,        2, 1));
`else
    vecs.push_back(mk(0, F3_W,  32'h502, 32'h0,        32'hCAFEF00D, 0, 0, 32'h500, 4'h0, 32'h0,        32'hCAFEF00D, 3, 0));
    vecs.push_back(mk(1, F3_H,  32'h303, 32'h1111BEEF, 32'h0,        0, 0, 32'h300, 4'hC, 32'hBEEFBEEF, 32'h0,        3, 0));
`endif
    vecs.push_back(mk(0, 3'b011, 32'h604, 32'h0,       32'h11223344, 0, 1, 32'h604, 4'h0, 32'h0,        32'h11223344, 4, 0));

    // Reset state
    repeat (2) @(negedge clk);
    check1("rst stall", stall, 1'b0);
    check1("rst done", done, 1'b0);
    check1("rst misalign_err", misalign_err, 1'b0);
    check1("rst bus_req", bus_req, 1'b0);
    check1("rst bus_we", bus_we, 1'b0);
    check("rst bus_addr", bus_addr, 32'h0);
    check("rst bus_wdata", bus_wdata, 32'h0);
    check("rst bus_wstrb", 32'(bus_wstrb), 32'h0);
    check("rst load_data", load_data, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Reset while waiting for read data abandons the access
    @(negedge clk);
    mem_read = 1'b1; funct3 = F3_H; addr = 32'h400; bus_rdata = 32'h12348001;
    @(negedge clk);
    check1("rstwait req", bus_req, 1'b1);
    bus_ready = 1'b1;
    @(negedge clk);
    check1("rstwait in_wait_stall", stall, 1'b1);
    check1("rstwait in_wait_req", bus_req, 1'b0);
    bus_ready = 1'b0; rst = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    check1("rstwait bus_req", bus_req, 1'b0);
    check1("rstwait stall", stall, 1'b0);
    check1("rstwait done", done, 1'b0);
    rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    model_load = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check1($sformatf("late_rvalid done c%0d", k), done, 1'b0);
      check1($sformatf("late_rvalid stall c%0d", k), stall, 1'b0);
      check1($sformatf("late_rvalid req c%0d", k), bus_req, 1'b0);
      check($sformatf("late_rvalid load_data c%0d", k), load_data, 32'h0);
    end
    bus_rvalid = 1'b0;

    // Recovery after reset
    run_vec(mk(0, F3_BU, 32'h203, 32'h0, 32'h80FF7F01, 0, 0, 32'h200, 4'h0, 32'h0, 32'h00000080, 3, 0), "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
